// File: rtl/vga_sync.sv
// vga_sync: 640x480 VGA timing generator for the pong display.
// Runs on the system clock and advances one pixel per p_tick. Provides
// active-low hsync/vsync, the current pixel coordinates, a visible-area
// flag and a one-clk strobe on the last pixel of each frame.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_tick
);

  // Totals must stay within 1024 so the 10-bit counters can hold them.
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_last;
  logic       v_last;

  // Sync pulses are active-low inside the inclusive [lo, hi] window.
  function automatic logic sync_level(input logic [9:0] cnt,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
    sync_level = !((cnt >= lo) && (cnt <= hi));
  endfunction

  assign h_last = (h_count == H_MAX);
  assign v_last = (v_count == V_MAX);

  // Next-state counters: advance on p_tick, v steps when h wraps.
  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (p_tick) begin
      if (h_last) begin
        h_next = '0;
        if (v_last) begin
          v_next = '0;
        end else begin
          v_next = v_count + 10'd1;
        end
      end else begin
        h_next = h_count + 10'd1;
      end
    end
  end

  // Counter and sync registers; syncs are decoded from the next-state
  // counters so they line up with the counters without a skew cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      h_count <= h_next;
      v_count <= v_next;
      hsync   <= sync_level(h_next, HS_START, HS_END);
      vsync   <= sync_level(v_next, VS_START, VS_END);
    end
  end

  assign x          = h_count;
  assign y          = v_count;
  assign video_on   = (h_count < H_VIS) && (v_count < V_VIS);
  assign frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync.sv
// Testbench for vga_sync. Horizontal timing uses the default 800-tick line;
// the vertical timing is shortened to 30 lines so whole frames fit in a
// short run. A tick-count reference model predicts every output each cycle.
module tb_vga_sync;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 20;
  localparam int V_FRONT   = 3;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 5;
  localparam int HT        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT        = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME     = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick = 1'b0;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_tick;

  vga_sync #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .p_tick(p_tick),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .x(x),
    .y(y),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   model_n = 0;
  bit   model_ok = 1'b0;
  int   cnt_hs_low, cnt_vs_low, cnt_ft, first_hs_x, fall_vid_x;
  logic prev_vid;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs derived from the number of ticks since reset.
  task automatic check_model();
    int ex, ey;
    logic ehs, evs, evid, eft;
    ex   = model_n % HT;
    ey   = model_n / HT;
    ehs  = !(ex >= H_DISPLAY + H_FRONT && ex < H_DISPLAY + H_FRONT + H_SYNC);
    evs  = !(ey >= V_DISPLAY + V_FRONT && ey < V_DISPLAY + V_FRONT + V_SYNC);
    evid = (ex < H_DISPLAY) && (ey < V_DISPLAY);
    eft  = p_tick && (model_n == FRAME - 1);
    chk("x", x, 10'(ex));
    chk("y", y, 10'(ey));
    chk("hsync", {9'b0, hsync}, {9'b0, ehs});
    chk("vsync", {9'b0, vsync}, {9'b0, evs});
    chk("video_on", {9'b0, video_on}, {9'b0, evid});
    chk("frame_tick", {9'b0, frame_tick}, {9'b0, eft});
  endtask

  task automatic clear_stats();
    cnt_hs_low = 0;
    cnt_vs_low = 0;
    cnt_ft     = 0;
    first_hs_x = -1;
    fall_vid_x = -1;
    prev_vid   = video_on;
  endtask

  // One clk cycle: drive inputs, check mid-cycle, then advance the model.
  task automatic cyc(input logic pt, input logic rs);
    p_tick = pt;
    reset  = rs;
    @(negedge clk);
    if (model_ok) check_model();
    if (hsync === 1'b0) begin
      cnt_hs_low++;
      if (first_hs_x < 0) first_hs_x = int'(x);
    end
    if (vsync === 1'b0) cnt_vs_low++;
    if (frame_tick === 1'b1) cnt_ft++;
    if (prev_vid === 1'b1 && video_on === 1'b0 && fall_vid_x < 0) fall_vid_x = int'(x);
    prev_vid = video_on;
    @(posedge clk);
    if (rs) begin
      model_n  = 0;
      model_ok = 1'b1;
    end else if (pt && model_ok) begin
      model_n = (model_n + 1) % FRAME;
    end
    #1;
  endtask

  initial begin
    clear_stats();

    // Reset held three cycles with p_tick high
    repeat (3) cyc(1'b1, 1'b1);
    chk("rst_x", x, 10'd0);
    chk("rst_y", y, 10'd0);
    chk("rst_hsync", {9'b0, hsync}, 10'd1);
    chk("rst_vsync", {9'b0, vsync}, 10'd1);
    chk("rst_video_on", {9'b0, video_on}, 10'd1);
    chk("rst_frame_tick", {9'b0, frame_tick}, 10'd0);

    // Full line at full rate
    clear_stats();
    repeat (HT) cyc(1'b1, 1'b0);
    chk("line_hs_low_cycles", 10'(cnt_hs_low), 10'(H_SYNC));
    chk("line_hs_first_x", 10'(first_hs_x), 10'(H_DISPLAY + H_FRONT));
    chk("line_vid_fall_x", 10'(fall_vid_x), 10'(H_DISPLAY));
    chk("line_end_x", x, 10'd0);
    chk("line_end_y", y, 10'd1);

    // Divided tick: one tick every 4 cycles, one line in 3200 cycles
    cyc(1'b1, 1'b1);
    clear_stats();
    for (int i = 0; i < 4 * HT; i++) cyc((i % 4) == 3, 1'b0);
    chk("div_end_x", x, 10'd0);
    chk("div_end_y", y, 10'd1);
    chk("div_hs_low_cycles", 10'(cnt_hs_low / 4), 10'(H_SYNC));

    // Whole frame at full rate
    cyc(1'b1, 1'b1);
    clear_stats();
    repeat (FRAME) cyc(1'b1, 1'b0);
    chk("frame_vs_low_lines", 10'(cnt_vs_low / HT), 10'(V_SYNC));
    chk("frame_vs_low_rem", 10'(cnt_vs_low % HT), 10'd0);
    chk("frame_tick_count", 10'(cnt_ft), 10'd1);
    chk("frame_end_x", x, 10'd0);
    chk("frame_end_y", y, 10'd0);

    // Stall inside the hsync pulse
    repeat (660) cyc(1'b1, 1'b0);
    chk("stall_pre_x", x, 10'd660);
    chk("stall_pre_hsync", {9'b0, hsync}, 10'd0);
    clear_stats();
    repeat (50) cyc(1'b0, 1'b0);
    chk("stall_x", x, 10'd660);
    chk("stall_y", y, 10'd0);
    chk("stall_hsync", {9'b0, hsync}, 10'd0);
    chk("stall_hs_low_cycles", 10'(cnt_hs_low), 10'd50);
    chk("stall_frame_tick", 10'(cnt_ft), 10'd0);

    // Reset mid-frame at x=700, y=15
    while (model_n != 15 * HT + 700) cyc(1'b1, 1'b0);
    chk("mid_pre_x", x, 10'd700);
    chk("mid_pre_y", y, 10'd15);
    cyc(1'b1, 1'b1);
    chk("mid_rst_x", x, 10'd0);
    chk("mid_rst_y", y, 10'd0);
    chk("mid_rst_hsync", {9'b0, hsync}, 10'd1);
    chk("mid_rst_vsync", {9'b0, vsync}, 10'd1);
    cyc(1'b1, 1'b0);
    chk("mid_resume_x", x, 10'd1);
    chk("mid_resume_y", y, 10'd0);

    // Random tick pattern across the frame wrap, then with sparse resets
    while (model_n != FRAME - 400) cyc(1'b1, 1'b0);
    clear_stats();
    repeat (3000) cyc($urandom_range(0, 3) != 0, 1'b0);
    chk("rand_wrap_frame_tick", 10'(cnt_ft), 10'd1);
    repeat (5000) cyc($urandom_range(0, 2) != 0, $urandom_range(0, 1999) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
